timer_ctrl: RTL
===============

# timer_ctrl

CHIP-8 delay/sound timer controller. It owns the two 8-bit architectural timers, DT and ST, and decrements them on each `timer_60hz_tick` pulse from `timer`. It arbitrates CPU writes (Fx15/Fx18) and reads (Fx07) against those decrements, and drives the buzzer while ST is non-zero. It sits between `timer` and the CPU execute stage.

## Interface
Parameters:
- `TONE_DIV`, default 100: clk cycles per buzzer half-period. Minimum 1. Only used with `TIMER_TONE_EN`.
- `TONE_W`, default 16: width of the tone divider counter. Must satisfy `TONE_DIV < 2**TONE_W`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active low.
- `timer_60hz_tick`  in  1  one-cycle decrement strobe from `timer`.
- `pause`  in  1  freezes both timers. Ticks seen while high are discarded, not deferred.
- `wr_en`  in  1  one-cycle write strobe.
- `wr_sel`  in  1  write target: 0 = DT, 1 = ST.
- `wr_data`  in  8  value to load.
- `rd_sel`  in  1  read source: 0 = DT, 1 = ST.
- `rd_data`  out  8  registered read data.
- `dt_zero`  out  1  high when DT == 0.
- `st_active`  out  1  high when ST != 0.
- `buzzer`  out  1  speaker drive.

## Operation
- State: `dt[7:0]` and `st[7:0]`.
- Decrement event: `timer_60hz_tick & ~pause`.
- At each rising edge, for each timer independently, first matching rule wins:
  - `wr_en` and `wr_sel` selects this timer: load `wr_data`.
  - Decrement event and timer != 0: timer - 1.
  - Otherwise: hold.
- A timer at 0 saturates at 0 and never wraps to 255.
- A write to one timer does not suppress the decrement of the other timer in the same cycle.
- Writing 0 is legal and stops that timer immediately.
- `rd_data <=` value of the timer selected by `rd_sel`, taken before this edge's update (pre-edge value).
- `dt_zero` and `st_active` are decoded combinationally from the registers.
- Buzzer state machine, two states:
  - SILENT: `buzzer` = 0, tone counter = 0. Go to TONE when the registered ST becomes non-zero.
  - TONE: drive `buzzer` (see Configuration). Go to SILENT on the edge after ST reaches 0.
- `pause` has no effect on the buzzer state machine.

## Timing
- Reset (async assert, sync release): `dt` = 0, `st` = 0, `rd_data` = 0, `buzzer` = 0, tone counter = 0, state SILENT. Therefore `dt_zero` = 1 and `st_active` = 0.
- Write latency: a write at edge N is visible in `dt`/`st` after N. A read issued in cycle N+1 returns the value in `rd_data` after edge N+1.
- Read latency: 1 cycle. Asserting `rd_sel` in the same cycle as a write returns the old value.
- Decrement latency: tick high in cycle N means the counter is decremented after edge N.
- Simultaneous events:
  - Write and tick to the same timer in one cycle: write wins; the loaded value is not decremented.
  - Tick while `pause` is high: dropped.
  - `pause` deasserting in the same cycle as a tick: the tick counts.
- Reset mid-operation: timers clear immediately and `buzzer` drops asynchronously. No pending tick or write survives reset.

## Configuration
- Macro `TIMER_TONE_EN`.
  - Defined: in TONE, `buzzer` is a square wave. It goes high on the first TONE cycle and toggles every `TONE_DIV` clk cycles. The tone counter runs 0..`TONE_DIV`-1 and wraps. Leaving TONE forces `buzzer` low and clears the counter.
  - Undefined: the tone counter is not built and `TONE_DIV`/`TONE_W` are ignored. `buzzer` is a registered level equal to `st_active` from the previous cycle, i.e. high throughout TONE.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-count with DT = 0x40 -> `dt_zero` = 1, `rd_data` = 0, `buzzer` = 0 without waiting for a clk edge.
- **Countdown:** write DT = 3, then apply 5 ticks -> DT reads 2, 1, 0, 0, 0; `dt_zero` rises after the 3rd tick.
- **Collision:** write ST = 5 with a tick in the same cycle while DT = 7 -> ST = 5 and DT = 6 afterwards.
- **Pause:** DT = 10, `pause` = 1 across 4 ticks, then released for 2 ticks -> DT = 8. The 4 paused ticks are lost.
- **Read path:** write DT = 0x2A in cycle N, `rd_sel` = 0 in cycle N+1 -> `rd_data` = 0x2A after edge N+1. A read issued in cycle N returns the old value.
- **Buzzer:** with `TIMER_TONE_EN` and `TONE_DIV` = 4, ST = 2 -> `buzzer` toggles every 4 cycles while ST != 0 and is low on the edge after the 2nd tick. Without the macro, `buzzer` is steady high for the same interval.

Source files
------------

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : timer_ctrl
// Description : CHIP-8 delay (DT) and sound (ST) timer controller. Owns both
//               8-bit timers, decrements them on each 60 Hz tick strobe,
//               arbitrates CPU loads and reads against those decrements and
//               drives the buzzer while ST is non-zero.
//
// Optional feature macro: TIMER_TONE_EN
//   defined   : buzzer is a square wave with a half-period of TONE_DIV clks
//   undefined : buzzer is a steady level (registered st_active); the tone
//               divider is not built and TONE_DIV / TONE_W are not used
//
// Parameters:
//   TONE_DIV        clk cycles per buzzer half-period (>= 1)
//   TONE_W          tone divider width, TONE_DIV < 2**TONE_W
//
// Ports:
//   clk             in   1  system clock, rising edge
//   rst_n           in   1  asynchronous reset, active low
//   timer_60hz_tick in   1  one-cycle decrement strobe
//   pause           in   1  freezes both timers; ticks seen while high are lost
//   wr_en           in   1  one-cycle write strobe
//   wr_sel          in   1  write target: 0 = DT, 1 = ST
//   wr_data         in   8  value to load
//   rd_sel          in   1  read source: 0 = DT, 1 = ST
//   rd_data         out  8  registered read data (pre-edge timer value)
//   dt_zero         out  1  DT == 0
//   st_active       out  1  ST != 0
//   buzzer          out  1  speaker drive
//
// Revision    : 1.0 - initial release
// ============================================================================
module timer_ctrl #(
    parameter int TONE_DIV = 100,
    parameter int TONE_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timer_60hz_tick,
    input  logic       pause,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [7:0] wr_data,
    input  logic       rd_sel,
    output logic [7:0] rd_data,
    output logic       dt_zero,
    output logic       st_active,
    output logic       buzzer
);

    // Parameter sanity check, evaluated at elaboration only.
    if ((TONE_DIV < 1) || (TONE_DIV >= (2 ** TONE_W))) begin : g_bad_tone_param
        $error("timer_ctrl: TONE_DIV must be in 1 .. 2**TONE_W-1");
    end

    // ------------------------------------------------------------------------
    // Timer registers
    // ------------------------------------------------------------------------
    logic [7:0] r_dt;
    logic [7:0] r_st;
    logic [7:0] r_rd_data;
    logic [7:0] w_dt_next;
    logic [7:0] w_st_next;
    logic       w_dec;
    logic       w_wr_dt;
    logic       w_wr_st;

    // A tick arriving while paused is simply dropped, never queued.
    assign w_dec   = timer_60hz_tick & ~pause;
    assign w_wr_dt = wr_en & ~wr_sel;
    assign w_wr_st = wr_en &  wr_sel;

    // Each timer resolves independently: a write to one never blocks the
    // decrement of the other. A write beats a decrement of the same timer,
    // and a timer at zero saturates rather than wrapping.
    always_comb begin
        w_dt_next = r_dt;
        if (w_wr_dt) begin
            w_dt_next = wr_data;
        end else if (w_dec && (r_dt != 8'd0)) begin
            w_dt_next = r_dt - 8'd1;
        end
    end

    always_comb begin
        w_st_next = r_st;
        if (w_wr_st) begin
            w_st_next = wr_data;
        end else if (w_dec && (r_st != 8'd0)) begin
            w_st_next = r_st - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dt      <= 8'd0;
            r_st      <= 8'd0;
            r_rd_data <= 8'd0;
        end else begin
            r_dt      <= w_dt_next;
            r_st      <= w_st_next;
            // Sample the pre-edge value so a read in the same cycle as a
            // write returns the old contents.
            r_rd_data <= rd_sel ? r_st : r_dt;
        end
    end

    assign rd_data   = r_rd_data;
    assign dt_zero   = (r_dt == 8'd0);
    assign st_active = (r_st != 8'd0);

    // ------------------------------------------------------------------------
    // Buzzer state machine (unaffected by pause)
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_SILENT = 1'b0,
        ST_TONE   = 1'b1
    } buz_state_t;

    buz_state_t r_state;
    buz_state_t w_state_next;
    logic       r_buzzer;
    logic       w_buzzer_next;

`ifdef TIMER_TONE_EN
    logic [TONE_W-1:0] r_tone_cnt;
    logic [TONE_W-1:0] w_tone_cnt_next;
    localparam logic [TONE_W-1:0] C_TONE_LAST = TONE_W'(TONE_DIV - 1);

    always_comb begin
        w_state_next    = r_state;
        w_buzzer_next   = 1'b0;
        w_tone_cnt_next = '0;
        case (r_state)
            ST_SILENT: begin
                if (st_active) begin
                    // First TONE cycle starts with the speaker high.
                    w_state_next  = ST_TONE;
                    w_buzzer_next = 1'b1;
                end
            end
            ST_TONE: begin
                if (!st_active) begin
                    w_state_next = ST_SILENT;
                end else if (r_tone_cnt == C_TONE_LAST) begin
                    w_buzzer_next   = ~r_buzzer;
                    w_tone_cnt_next = '0;
                end else begin
                    w_buzzer_next   = r_buzzer;
                    w_tone_cnt_next = r_tone_cnt + TONE_W'(1);
                end
            end
            default: begin
                w_state_next = ST_SILENT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tone_cnt <= '0;
        end else begin
            r_tone_cnt <= w_tone_cnt_next;
        end
    end
`else
    // Without the tone divider the speaker is a steady level that follows
    // st_active one cycle late, i.e. high for the whole TONE state.
    always_comb begin
        w_state_next  = r_state;
        w_buzzer_next = 1'b0;
        case (r_state)
            ST_SILENT: begin
                if (st_active) begin
                    w_state_next  = ST_TONE;
                    w_buzzer_next = 1'b1;
                end
            end
            ST_TONE: begin
                if (!st_active) begin
                    w_state_next = ST_SILENT;
                end else begin
                    w_buzzer_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_SILENT;
            end
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_SILENT;
            r_buzzer <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_buzzer <= w_buzzer_next;
        end
    end

    assign buzzer = r_buzzer;

endmodule
`default_nettype wire
